// File: rtl/rand_rx_pkg.sv
// rand_rx_pkg: shared types and default sizing for the random serial receive path
package rand_rx_pkg;
  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_MAX_RUN = 16;
endpackage

// File: rtl/run_length_monitor.sv
// run_length_monitor: flags a stream that repeats the same bit MAX_RUN times in a row
module run_length_monitor
  import rand_rx_pkg::*;
#(
  parameter int MAX_RUN = DEF_MAX_RUN
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic enable,
  input  logic clear,
  output logic stuck
);
  localparam int RW = $clog2(MAX_RUN + 1);
  logic [RW-1:0] run, run_n;
  logic last, hit;
  // run==0 marks "no sample seen yet", so the first sample always starts a run of 1
  always_comb begin
    run_n = (run == '0 || sample != last) ? RW'(1) : (run == RW'(MAX_RUN)) ? run : run + 1'b1;
    hit = enable && run_n == RW'(MAX_RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= '0;
      last <= 1'b0;
      stuck <= 1'b0;
    end else begin
      if (enable) begin
        run <= run_n;
        last <= sample;
      end
      stuck <= hit | (stuck & ~clear);
    end
  end
endmodule

// File: rtl/rand_serial_collector.sv
// rand_serial_collector: assembles MSB-first words from a random serial stream into a
// one-entry valid/ready holding register; RAND_RUN_CHECK_EN adds stuck-stream detection.
module rand_serial_collector
  import rand_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_RUN = DEF_MAX_RUN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  input  logic             clr_stat,
  output logic             overflow,
  output logic             stuck
);
  localparam int CW = $clog2(WIDTH);
  hold_state_t state, state_n;
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] word;
  logic complete, load, drop;
  always_comb begin
    complete = ser_en && cnt == CW'(WIDTH - 1);
    word = {shreg, ser_in};
    load = complete && (state == HOLD_EMPTY || word_ready);
    drop = complete && state == HOLD_FULL && !word_ready;
    state_n = complete ? HOLD_FULL : (state == HOLD_FULL && word_ready) ? HOLD_EMPTY : state;
  end
  assign word_valid = state == HOLD_FULL;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HOLD_EMPTY;
    else state <= state_n;
  end
  // capture never waits on the consumer; only the holding register sees backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt <= '0;
      word_out <= '0;
      overflow <= 1'b0;
    end else begin
      if (ser_en) begin
        shreg <= word[WIDTH-2:0];
        cnt <= complete ? '0 : cnt + 1'b1;
      end
      if (load) word_out <= word;
      overflow <= drop | (overflow & ~clr_stat);
    end
  end
`ifdef RAND_RUN_CHECK_EN
  run_length_monitor #(.MAX_RUN(MAX_RUN)) u_run (
    .clk(clk),
    .rst(rst),
    .sample(ser_in),
    .enable(ser_en),
    .clear(clr_stat),
    .stuck(stuck)
  );
`else
  assign stuck = 1'b0;
`endif
endmodule

// File: tb/tb_rand_serial_collector.sv
// tb_rand_serial_collector: directed and random stimulus against a word-level reference model
module tb_rand_serial_collector;
  localparam int W = 8;
  localparam int MR = 16;
`ifdef RAND_RUN_CHECK_EN
  localparam logic STUCK_ON = 1'b1;
`else
  localparam logic STUCK_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ser_in = 1'b0, ser_en = 1'b0, word_ready = 1'b0, clr_stat = 1'b0;
  logic [W-1:0] word_out;
  logic word_valid, overflow, stuck;
  int passed = 0, total = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc = '0, m_out = '0;
  int nb = 0, run = 0;
  logic m_full = 1'b0, m_ovf = 1'b0, m_stuck = 1'b0, lastb = 1'b0;

  rand_serial_collector #(.WIDTH(W), .MAX_RUN(MR)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .clr_stat(clr_stat),
    .overflow(overflow), .stuck(stuck)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard monitor: a transfer happens at the coming edge whenever valid && ready
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL sb_word: got %0h expected <none> at %0t", word_out, $time);
      else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (word_out === e) passed++;
        else $display("FAIL sb_word: got %0h expected %0h at %0t", word_out, e, $time);
      end
    end
  end

  task automatic model_reset();
    acc = '0; m_out = '0; nb = 0; run = 0;
    m_full = 1'b0; m_ovf = 1'b0; m_stuck = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 32'(word_valid), 32'(m_full));
    check({tag, "_out"}, 32'(word_out), 32'(m_out));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_stuck"}, 32'(stuck), 32'(m_stuck));
  endtask

  // one clock of stimulus; the model is advanced by the rules for this edge
  task automatic step(input logic en, input logic b, input logic rdy, input logic clr);
    logic dropped, complete;
    ser_en = en; ser_in = b; word_ready = rdy; clr_stat = clr;
    dropped = 1'b0;
    complete = 1'b0;
    if (en) begin
      acc = {acc[W-2:0], b};
      nb++;
      run = (run == 0 || b != lastb) ? 1 : run + 1;
      lastb = b;
      complete = (nb == W);
    end
    if (complete) begin
      nb = 0;
      if (m_full && !rdy) dropped = 1'b1;
      else begin
        exp_q.push_back(acc);
        m_out = acc;
        m_full = 1'b1;
      end
    end else if (m_full && rdy) m_full = 1'b0;
    m_ovf = dropped ? 1'b1 : (clr ? 1'b0 : m_ovf);
`ifdef RAND_RUN_CHECK_EN
    m_stuck = (en && run >= MR) ? 1'b1 : (clr ? 1'b0 : m_stuck);
`endif
    @(posedge clk);
    #1;
    check_state("step");
  endtask

  task automatic reset_mid();
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_out", 32'(word_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w5a, wa5;
    logic b;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b1, 1'b0);
    reset_mid();
    send_word(8'hB2, 1'b1);
    check("b2_valid", 32'(word_valid), 32'd1);
    check("b2_word", 32'(word_out), 32'hB2);
    drain();
    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    check("bp_word", 32'(word_out), 32'h3C);
    check("bp_ovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    drain();
    w5a = 8'h5A;
    for (int i = 0; i < 2 * W; i++) step(~i[0], w5a[W - 1 - i / 2], 1'b0, 1'b0);
    check("alt_word", 32'(word_out), 32'h5A);
    drain();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    reset_mid();
    wa5 = 8'hA5;
    send_word(wa5, 1'b0);
    check("post_rst_word", 32'(word_out), 32'hA5);
    drain();
    reset_mid();
    for (int i = 0; i < MR - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("run15_stuck", 32'(stuck), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("run16_stuck", 32'(stuck), 32'(STUCK_ON));
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("stuck_clr", 32'(stuck), 32'd0);
    for (int i = 0; i < MR - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("run15_then0", 32'(stuck), 32'd0);
    drain();
    b = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) reset_mid();
      b = (i < 300) ? 1'($urandom_range(0, 1)) : (($urandom_range(0, 19) == 0) ? ~b : b);
      step($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    drain();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
